// File: rtl/eject_checker_pkg.sv
// Shared definitions for the eject-side packet checker: flit layout, flit types,
// port indices and error-flag bit positions.
package eject_checker_pkg;

  localparam int FLIT_SIZE = 128;
  localparam int XSIZE     = 8;
  localparam int YSIZE     = 8;
  localparam int ZSIZE     = 8;
  localparam int NUM_PORTS = 6;

  typedef enum logic [1:0] {
    HEAD_FLIT = 2'b00,
    BODY_FLIT = 2'b01,
    TAIL_FLIT = 2'b10,
    BAD_FLIT  = 2'b11
  } flit_type_e;

  typedef enum logic {
    ST_IDLE,
    ST_RECV
  } port_state_e;

  // Flit field offsets, MSB first: type, dvld, z, y, x, tag, payload
  localparam int TYPE_MSB  = 127;
  localparam int DVLD_BIT  = 125;
  localparam int Z_LSB     = 122;
  localparam int Y_LSB     = 119;
  localparam int X_LSB     = 116;
  localparam int TAG_LSB   = 112;
  localparam int PAYLOAD_W = 108;

  localparam int PORT_XPOS = 0;
  localparam int PORT_YPOS = 1;
  localparam int PORT_ZPOS = 2;
  localparam int PORT_XNEG = 3;
  localparam int PORT_YNEG = 4;
  localparam int PORT_ZNEG = 5;

  localparam int ERR_DEST    = 0;
  localparam int ERR_SEQ     = 1;
  localparam int ERR_LEN     = 2;
  localparam int ERR_PAYLOAD = 3;

  localparam logic [PAYLOAD_W-1:0] PAYLOAD_HT   = 108'hEAD;
  localparam logic [PAYLOAD_W-1:0] PAYLOAD_BODY = 108'hD;

endpackage

// File: rtl/eject_checker_if.sv
// Bundle of the six eject ports (router side) and the checker's status outputs.
interface eject_checker_if;
  import eject_checker_pkg::*;

  logic [FLIT_SIZE-1:0] eject_xpos, eject_ypos, eject_zpos;
  logic [FLIT_SIZE-1:0] eject_xneg, eject_yneg, eject_zneg;
  logic                 eject_xpos_valid, eject_ypos_valid, eject_zpos_valid;
  logic                 eject_xneg_valid, eject_yneg_valid, eject_zneg_valid;

  logic [6*16-1:0]      pkt_count;
  logic [6*4-1:0]       err_flags;
  logic                 first_err_valid;
  logic [2:0]           first_err_port;
  logic [FLIT_SIZE-1:0] first_err_flit;
  logic                 done;

  modport master (
    output eject_xpos, eject_ypos, eject_zpos, eject_xneg, eject_yneg, eject_zneg,
    output eject_xpos_valid, eject_ypos_valid, eject_zpos_valid,
    output eject_xneg_valid, eject_yneg_valid, eject_zneg_valid,
    input  pkt_count, err_flags, first_err_valid, first_err_port, first_err_flit, done
  );

  modport slave (
    input  eject_xpos, eject_ypos, eject_zpos, eject_xneg, eject_yneg, eject_zneg,
    input  eject_xpos_valid, eject_ypos_valid, eject_zpos_valid,
    input  eject_xneg_valid, eject_yneg_valid, eject_zneg_valid,
    output pkt_count, err_flags, first_err_valid, first_err_port, first_err_flit, done
  );

endinterface

// File: rtl/eject_checker_port.sv
// Single eject-port checker: packet FSM, flit counter, good-packet counter, sticky flags.
// Payload comparison is built only when PAYLOAD_CHECK_EN is defined.
module eject_port_checker
  import eject_checker_pkg::*;
#(
  parameter logic [2:0]  cur_x       = 3'd0,
  parameter logic [2:0]  cur_y       = 3'd0,
  parameter logic [2:0]  cur_z       = 3'd0,
  parameter int unsigned packet_size = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [FLIT_SIZE-1:0] flit_i,
  input  logic                 valid_i,
  output logic [15:0]          pkt_count_o,
  output logic [3:0]           err_flags_o,
  output logic [3:0]           err_now_o
);

  localparam logic [9:0] PKT_LEN = 10'(packet_size);

  port_state_e state_q, state_d;
  logic [9:0]  cnt_q, cnt_d;
  logic        bad_q, bad_d;
  logic [15:0] pcnt_q;
  logic [3:0]  flags_q;
  logic [3:0]  err_d;
  logic        count_en;
  logic        start_pkt;

  flit_type_e ftype;
  logic       dest_mis;
  logic       pay_mis;
  logic [9:0] cnt_inc;
  logic       unused_bits;

  assign ftype    = flit_type_e'(flit_i[TYPE_MSB -: 2]);
  assign dest_mis = !(flit_i[DVLD_BIT] && flit_i[Z_LSB +: 3] == cur_z &&
                      flit_i[Y_LSB +: 3] == cur_y && flit_i[X_LSB +: 3] == cur_x);
  assign cnt_inc  = cnt_q + 10'd1;
  assign unused_bits = ^flit_i[TAG_LSB+3:0];

`ifdef PAYLOAD_CHECK_EN
  assign pay_mis = flit_i[PAYLOAD_W-1:0] != ((ftype == BODY_FLIT) ? PAYLOAD_BODY : PAYLOAD_HT);
`else
  assign pay_mis = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bad_d     = bad_q;
    err_d     = '0;
    count_en  = 1'b0;
    start_pkt = 1'b0;
    if (valid_i) begin
      if (ftype == BAD_FLIT) begin
        err_d[ERR_SEQ] = 1'b1;
      end else if (state_q == ST_IDLE) begin
        if (ftype == HEAD_FLIT) start_pkt = 1'b1;
        else                    err_d[ERR_SEQ] = 1'b1;
      end else begin
        case (ftype)
          HEAD_FLIT: begin
            // A new head mid-packet abandons the old one and restarts.
            err_d[ERR_SEQ] = 1'b1;
            start_pkt      = 1'b1;
          end
          BODY_FLIT: begin
            cnt_d = cnt_inc;
            if (pay_mis) begin
              err_d[ERR_PAYLOAD] = 1'b1;
              bad_d              = 1'b1;
            end
            if (cnt_inc == PKT_LEN) begin
              err_d[ERR_LEN] = 1'b1;
              state_d        = ST_IDLE;
            end
          end
          TAIL_FLIT: begin
            err_d[ERR_PAYLOAD] = pay_mis;
            if (cnt_inc != PKT_LEN) err_d[ERR_LEN] = 1'b1;
            else if (!bad_q && !pay_mis) count_en = 1'b1;
            cnt_d   = '0;
            state_d = ST_IDLE;
          end
          default: ;
        endcase
      end
      if (start_pkt) begin
        cnt_d              = 10'd1;
        bad_d              = dest_mis | pay_mis;
        err_d[ERR_DEST]    = dest_mis;
        err_d[ERR_PAYLOAD] = pay_mis;
        state_d            = ST_RECV;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bad_q   <= 1'b0;
      pcnt_q  <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bad_q   <= bad_d;
      flags_q <= flags_q | err_d;
      if (count_en && pcnt_q != 16'hFFFF) pcnt_q <= pcnt_q + 16'd1;
    end
  end

  assign pkt_count_o = pcnt_q;
  assign err_flags_o = flags_q;
  assign err_now_o   = err_d;

endmodule

// File: rtl/eject_checker.sv
// Eject-side traffic checker: six independent port checkers, lowest-index-wins
// first-error capture and a registered done. Optional payload check: PAYLOAD_CHECK_EN.
module eject_checker
  import eject_checker_pkg::*;
#(
  parameter logic [2:0]  cur_x       = 3'd0,
  parameter logic [2:0]  cur_y       = 3'd0,
  parameter logic [2:0]  cur_z       = 3'd0,
  parameter int unsigned packet_size = 16,
  parameter int unsigned packet_num  = 10
) (
  input logic           clk,
  input logic           rst,
  eject_checker_if.slave bus
);

  logic [FLIT_SIZE-1:0] flits    [NUM_PORTS];
  logic                 valids   [NUM_PORTS];
  logic [15:0]          counts   [NUM_PORTS];
  logic [3:0]           err_now  [NUM_PORTS];

  assign flits[PORT_XPOS]  = bus.eject_xpos;
  assign flits[PORT_YPOS]  = bus.eject_ypos;
  assign flits[PORT_ZPOS]  = bus.eject_zpos;
  assign flits[PORT_XNEG]  = bus.eject_xneg;
  assign flits[PORT_YNEG]  = bus.eject_yneg;
  assign flits[PORT_ZNEG]  = bus.eject_zneg;
  assign valids[PORT_XPOS] = bus.eject_xpos_valid;
  assign valids[PORT_YPOS] = bus.eject_ypos_valid;
  assign valids[PORT_ZPOS] = bus.eject_zpos_valid;
  assign valids[PORT_XNEG] = bus.eject_xneg_valid;
  assign valids[PORT_YNEG] = bus.eject_yneg_valid;
  assign valids[PORT_ZNEG] = bus.eject_zneg_valid;

  generate
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      eject_port_checker #(
        .cur_x(cur_x), .cur_y(cur_y), .cur_z(cur_z), .packet_size(packet_size)
      ) u_chk (
        .clk         (clk),
        .rst         (rst),
        .flit_i      (flits[gi]),
        .valid_i     (valids[gi]),
        .pkt_count_o (bus.pkt_count[16*gi +: 16]),
        .err_flags_o (bus.err_flags[4*gi +: 4]),
        .err_now_o   (err_now[gi])
      );
      assign counts[gi] = bus.pkt_count[16*gi +: 16];
    end
  endgenerate

  logic                 sel_valid;
  logic [2:0]           sel_port;
  logic [FLIT_SIZE-1:0] sel_flit;
  logic                 all_met;

  // Scan from the top down so the lowest erroring port is the one left selected.
  always_comb begin
    sel_valid = 1'b0;
    sel_port  = '0;
    sel_flit  = '0;
    all_met   = 1'b1;
    for (int p = NUM_PORTS - 1; p >= 0; p--) begin
      if (|err_now[p]) begin
        sel_valid = 1'b1;
        sel_port  = 3'(p);
        sel_flit  = flits[p];
      end
      if (32'(counts[p]) < packet_num) all_met = 1'b0;
    end
  end

  logic                 first_valid_q;
  logic [2:0]           first_port_q;
  logic [FLIT_SIZE-1:0] first_flit_q;
  logic                 done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first_valid_q <= 1'b0;
      first_port_q  <= '0;
      first_flit_q  <= '0;
      done_q        <= 1'b0;
    end else begin
      if (sel_valid && !first_valid_q) begin
        first_valid_q <= 1'b1;
        first_port_q  <= sel_port;
        first_flit_q  <= sel_flit;
      end
      done_q <= all_met;
    end
  end

  assign bus.first_err_valid = first_valid_q;
  assign bus.first_err_port  = first_port_q;
  assign bus.first_err_flit  = first_flit_q;
  assign bus.done            = done_q;

endmodule

// File: tb/tb_eject_checker.sv
// Directed self-checking bench for eject_checker at node (x=1,y=2,z=3), 16-flit packets.
module tb_eject_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [127:0] flit_a [6];
  logic         vld_a  [6];

  int errors = 0;
  int checks = 0;

  eject_checker_if bus();

  assign bus.eject_xpos = flit_a[0];
  assign bus.eject_ypos = flit_a[1];
  assign bus.eject_zpos = flit_a[2];
  assign bus.eject_xneg = flit_a[3];
  assign bus.eject_yneg = flit_a[4];
  assign bus.eject_zneg = flit_a[5];
  assign bus.eject_xpos_valid = vld_a[0];
  assign bus.eject_ypos_valid = vld_a[1];
  assign bus.eject_zpos_valid = vld_a[2];
  assign bus.eject_xneg_valid = vld_a[3];
  assign bus.eject_yneg_valid = vld_a[4];
  assign bus.eject_zneg_valid = vld_a[5];

  eject_checker #(
    .cur_x(3'd1), .cur_y(3'd2), .cur_z(3'd3), .packet_size(16), .packet_num(10)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [127:0] mk(input logic [1:0] t, input logic dv,
                                      input logic [2:0] z, input logic [2:0] y,
                                      input logic [2:0] x, input logic [107:0] pay);
    return {t, dv, z, y, x, 4'h5, 4'h0, pay};
  endfunction

  logic [127:0] good_head, good_body, good_tail;

  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++) vld_a[i] = 1'b0;
  endtask

  task automatic send_flit(input int p, input logic [127:0] f);
    flit_a[p] = f;
    vld_a[p]  = 1'b1;
    step();
  endtask

  task automatic send_pkt(input int p, input int nbody);
    send_flit(p, good_head);
    for (int i = 0; i < nbody; i++) send_flit(p, good_body);
    send_flit(p, good_tail);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.pkt_count !== 96'h0) begin errors++; $display("FAIL reset_count got=%h exp=0", bus.pkt_count); end
    checks++; if (bus.err_flags !== 24'h0) begin errors++; $display("FAIL reset_flags got=%h exp=0", bus.err_flags); end
    checks++; if (bus.first_err_valid !== 1'b0) begin errors++; $display("FAIL reset_first_err got=%b exp=0", bus.first_err_valid); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    rst = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_single_packet();
    do_reset();
    send_flit(0, good_head);
    for (int i = 0; i < 14; i++) send_flit(0, good_body);
    checks++; if (bus.pkt_count !== 96'h0) begin errors++; $display("FAIL single_before_tail got=%h exp=0", bus.pkt_count); end
    send_flit(0, good_tail);
    checks++; if (bus.pkt_count !== 96'h1) begin errors++; $display("FAIL single_count got=%h exp=1", bus.pkt_count); end
    checks++; if (bus.err_flags !== 24'h0) begin errors++; $display("FAIL single_flags got=%h exp=0", bus.err_flags); end
    $display("test_single_packet count=%h flags=%h", bus.pkt_count, bus.err_flags);
  endtask

  task automatic test_all_ports_done();
    do_reset();
    for (int k = 0; k < 10; k++) begin
      for (int f = 0; f < 16; f++) begin
        for (int p = 0; p < 6; p++) begin
          flit_a[p] = (f == 0) ? good_head : (f == 15) ? good_tail : good_body;
          vld_a[p]  = 1'b1;
        end
        step();
      end
    end
    for (int p = 0; p < 6; p++) begin
      checks++;
      if (bus.pkt_count[16*p +: 16] !== 16'd10) begin
        errors++; $display("FAIL all_count port=%0d got=%0d exp=10", p, bus.pkt_count[16*p +: 16]);
      end
    end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL done_early got=%b exp=0", bus.done); end
    step();
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL done_rise got=%b exp=1", bus.done); end
    checks++; if (bus.err_flags !== 24'h0) begin errors++; $display("FAIL all_flags got=%h exp=0", bus.err_flags); end
    $display("test_all_ports_done count=%h done=%b", bus.pkt_count, bus.done);
  endtask

  task automatic test_dest();
    logic [127:0] bad_head;
    bad_head = mk(2'b00, 1'b1, 3'd3, 3'd2, 3'd2, 108'hEAD);
    do_reset();
    send_flit(4, bad_head);
    for (int i = 0; i < 14; i++) send_flit(4, good_body);
    send_flit(4, good_tail);
    checks++; if (bus.err_flags !== 24'h010000) begin errors++; $display("FAIL dest_flags got=%h exp=010000", bus.err_flags); end
    checks++; if (bus.first_err_port !== 3'd4) begin errors++; $display("FAIL dest_port got=%0d exp=4", bus.first_err_port); end
    checks++; if (bus.first_err_flit !== bad_head) begin errors++; $display("FAIL dest_flit got=%h exp=%h", bus.first_err_flit, bad_head); end
    checks++; if (bus.pkt_count !== 96'h0) begin errors++; $display("FAIL dest_count got=%h exp=0", bus.pkt_count); end
    $display("test_dest flags=%h port=%0d", bus.err_flags, bus.first_err_port);
  endtask

  task automatic test_len();
    do_reset();
    send_pkt(2, 8);
    checks++; if (bus.err_flags !== 24'h000400) begin errors++; $display("FAIL len_flags got=%h exp=000400", bus.err_flags); end
    checks++; if (bus.pkt_count !== 96'h0) begin errors++; $display("FAIL len_count0 got=%h exp=0", bus.pkt_count); end
    send_pkt(2, 14);
    checks++; if (bus.pkt_count[47:32] !== 16'd1) begin errors++; $display("FAIL len_recover got=%0d exp=1", bus.pkt_count[47:32]); end
    $display("test_len flags=%h count=%h", bus.err_flags, bus.pkt_count);
  endtask

  task automatic test_long();
    do_reset();
    send_flit(0, good_head);
    for (int i = 0; i < 15; i++) send_flit(0, good_body);
    checks++; if (bus.err_flags !== 24'h000004) begin errors++; $display("FAIL long_len got=%h exp=000004", bus.err_flags); end
    send_flit(0, good_tail);
    checks++; if (bus.err_flags !== 24'h000006) begin errors++; $display("FAIL long_seq got=%h exp=000006", bus.err_flags); end
    checks++; if (bus.pkt_count !== 96'h0) begin errors++; $display("FAIL long_count got=%h exp=0", bus.pkt_count); end
    $display("test_long flags=%h", bus.err_flags);
  endtask

  task automatic test_concurrent_seq();
    do_reset();
    send_flit(1, good_head);
    flit_a[1] = good_head; vld_a[1] = 1'b1;
    flit_a[3] = good_body; vld_a[3] = 1'b1;
    step();
    checks++; if (bus.err_flags !== 24'h002020) begin errors++; $display("FAIL seq_flags got=%h exp=002020", bus.err_flags); end
    checks++; if (bus.first_err_port !== 3'd1) begin errors++; $display("FAIL seq_port got=%0d exp=1", bus.first_err_port); end
    for (int i = 0; i < 14; i++) send_flit(1, good_body);
    send_flit(1, good_tail);
    checks++; if (bus.pkt_count !== (96'h1 << 16)) begin errors++; $display("FAIL seq_restart_count got=%h exp=%h", bus.pkt_count, 96'h1 << 16); end
    $display("test_concurrent_seq flags=%h port=%0d", bus.err_flags, bus.first_err_port);
  endtask

  task automatic test_bad_type();
    do_reset();
    send_flit(0, good_head);
    for (int i = 0; i < 7; i++) send_flit(0, good_body);
    send_flit(0, mk(2'b11, 1'b1, 3'd3, 3'd2, 3'd1, 108'hD));
    for (int i = 0; i < 7; i++) send_flit(0, good_body);
    send_flit(0, good_tail);
    checks++; if (bus.err_flags !== 24'h000002) begin errors++; $display("FAIL type11_flags got=%h exp=000002", bus.err_flags); end
    checks++; if (bus.pkt_count !== 96'h1) begin errors++; $display("FAIL type11_count got=%h exp=1", bus.pkt_count); end
    $display("test_bad_type flags=%h count=%h", bus.err_flags, bus.pkt_count);
  endtask

  task automatic test_payload();
    do_reset();
    send_flit(0, good_head);
    for (int i = 0; i < 6; i++) send_flit(0, good_body);
    send_flit(0, mk(2'b01, 1'b1, 3'd3, 3'd2, 3'd1, 108'hE));
    for (int i = 0; i < 7; i++) send_flit(0, good_body);
    send_flit(0, good_tail);
`ifdef PAYLOAD_CHECK_EN
    checks++; if (bus.err_flags !== 24'h000008) begin errors++; $display("FAIL payload_flags got=%h exp=000008", bus.err_flags); end
    checks++; if (bus.pkt_count !== 96'h0) begin errors++; $display("FAIL payload_count got=%h exp=0", bus.pkt_count); end
`else
    checks++; if (bus.err_flags !== 24'h000000) begin errors++; $display("FAIL payload_flags got=%h exp=000000", bus.err_flags); end
    checks++; if (bus.pkt_count !== 96'h1) begin errors++; $display("FAIL payload_count got=%h exp=1", bus.pkt_count); end
`endif
    $display("test_payload flags=%h count=%h", bus.err_flags, bus.pkt_count);
  endtask

  task automatic test_rst_mid();
    do_reset();
    send_flit(5, good_head);
    for (int i = 0; i < 4; i++) send_flit(5, good_body);
    do_reset();
    send_pkt(5, 14);
    checks++; if (bus.pkt_count !== (96'h1 << 80)) begin errors++; $display("FAIL rstmid_count got=%h exp=%h", bus.pkt_count, 96'h1 << 80); end
    checks++; if (bus.err_flags !== 24'h0) begin errors++; $display("FAIL rstmid_flags got=%h exp=0", bus.err_flags); end
    checks++; if (bus.first_err_valid !== 1'b0) begin errors++; $display("FAIL rstmid_first got=%b exp=0", bus.first_err_valid); end
    $display("test_rst_mid count=%h flags=%h", bus.pkt_count, bus.err_flags);
  endtask

  initial begin
    good_head = mk(2'b00, 1'b1, 3'd3, 3'd2, 3'd1, 108'hEAD);
    good_body = mk(2'b01, 1'b1, 3'd3, 3'd2, 3'd1, 108'hD);
    good_tail = mk(2'b10, 1'b1, 3'd3, 3'd2, 3'd1, 108'hEAD);
    for (int i = 0; i < 6; i++) begin
      flit_a[i] = '0;
      vld_a[i]  = 1'b0;
    end
    test_reset();
    test_single_packet();
    test_all_ports_done();
    test_dest();
    test_len();
    test_long();
    test_concurrent_seq();
    test_bad_type();
    test_payload();
    test_rst_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
